tx_arbiter: RTL
===============

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 Parameter TO_CYC, default 16'd50000: max cycles from trmt to tx_done before timeout.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 cmd_req  input  1  command-response requester wants one byte sent; level, held until cmd_ack.
REQ-005 cmd_data  input  8  command-response byte; stable while cmd_req high.
REQ-006 cmd_ack  output  1  one-cycle pulse: cmd byte finished (sent or dropped).
REQ-007 ram_req  input  1  RAM-dump requester wants one byte sent; level, held until ram_ack.
REQ-008 ram_data  input  8  RAM-dump byte; stable while ram_req high.
REQ-009 ram_ack  output  1  one-cycle pulse: ram byte finished (sent or dropped).
REQ-010 trmt  output  1  one-cycle pulse to UART transmitter starting a byte.
REQ-011 tx_data  output  8  registered byte to UART; held from trmt until return to IDLE.
REQ-012 tx_done  input  1  UART byte-complete pulse.
REQ-013 clr_err  input  1  clears timeout_err.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 grant_id  output  1  0 = cmd, 1 = ram; owner of current transfer, valid while busy.
REQ-016 timeout_err  output  1  sticky flag: a transfer timed out.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, WAIT, ACK; exactly one byte per IDLE->ACK pass.
REQ-018 IDLE: no req -> stay; any req -> latch winner's data into tx_data, set grant_id, go LOAD.
REQ-019 Arbitration: single req wins; both high -> requester not in last_grant wins (round-robin); last_grant updated on entering LOAD.
REQ-020 LOAD: trmt=1 for this one cycle, clear timeout counter, go WAIT; so trmt is asserted exactly 1 cycle after req is sampled in IDLE.
REQ-021 WAIT: tx_done=1 -> go ACK; else increment 16-bit counter; counter == TO_CYC-1 without tx_done -> set timeout_err, go ACK.
REQ-022 ACK: assert ack of grant_id owner only (cmd_ack or ram_ack, never both), go IDLE; ack is 1 cycle after tx_done.
REQ-023 Requester drops req or presents next byte in the cycle after its ack; the IDLE following ACK re-arbitrates normally.
REQ-024 tx_done in IDLE, LOAD or ACK SHALL be ignored.
REQ-025 tx_done coincident with counter reaching TO_CYC-1: tx_done wins, timeout_err unchanged.
REQ-026 clr_err clears timeout_err next cycle; simultaneous set and clr: set wins.
REQ-027 Req deasserted mid-transfer SHALL NOT abort the transfer; ack still pulses.
REQ-028 Outputs trmt, cmd_ack, ram_ack, busy SHALL be decoded from registered state only (no input-to-output combinational path).

Reset
REQ-029 rst SHALL force state IDLE, trmt=0, tx_data=8'h00, cmd_ack=0, ram_ack=0, busy=0, grant_id=0, timeout_err=0, counter=0, last_grant=ram (cmd wins first tie).
REQ-030 rst mid-transfer SHALL abandon the byte with no ack; next tx_done ignored unless in WAIT.

Verification
REQ-031 cmd_req=1, cmd_data=8'hA5 from reset -> trmt 1 cycle after IDLE sample, tx_data=8'hA5, grant_id=0; tx_done 10 cycles later -> cmd_ack pulse next cycle, busy=0 the cycle after.
REQ-032 cmd_req and ram_req both held, each presenting new byte after ack -> grants alternate cmd, ram, cmd, ram over 4 bytes; no consecutive repeat.
REQ-033 ram_req only, ram_data 8'h00..8'h07 streamed -> 8 trmt pulses, 8 ram_ack pulses, tx_data sequence matches, cmd_ack never asserted.
REQ-034 TO_CYC=16, no tx_done -> timeout_err=1 after 16 WAIT cycles, owner ack pulses, FSM returns IDLE; clr_err -> timeout_err=0.
REQ-035 rst asserted during WAIT, then tx_done pulsed -> no ack, no trmt, all outputs at reset values.
REQ-036 tx_done pulsed while IDLE and during LOAD -> no state change, no ack.

Source files
------------

// File: rtl/tx_arbiter.sv
// Round-robin arbiter feeding single bytes from a command requester and a RAM-dump
// requester into a UART transmitter, with a per-byte completion timeout.
//   state | meaning
//   IDLE  | no transfer; sample requests and pick a winner
//   LOAD  | pulse trmt to the UART, clear the timeout counter
//   WAIT  | wait for tx_done or timeout
//   ACK   | pulse the owner's ack, then return to IDLE
module tx_arbiter #(
    parameter logic [15:0] TO_CYC = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_req,
    input  logic [7:0] cmd_data,
    output logic       cmd_ack,
    input  logic       ram_req,
    input  logic [7:0] ram_data,
    output logic       ram_ack,
    output logic       trmt,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    input  logic       clr_err,
    output logic       busy,
    output logic       grant_id,
    output logic       timeout_err
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, ACK} state_t;

    state_t      state, state_nxt;
    logic [15:0] counter;
    logic        last_grant;
    logic        pick_ram;
    logic        load_en;
    logic        err_set;

    // On a tie the requester that did not win last time gets the byte.
    assign pick_ram = ram_req && (!cmd_req || !last_grant);

    always_comb begin
        state_nxt = state;
        load_en   = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_req || ram_req) begin
                    state_nxt = LOAD;
                    load_en   = 1'b1;
                end
            end
            LOAD: state_nxt = WAIT;
            WAIT: begin
                if (tx_done) begin
                    state_nxt = ACK;
                end else if (counter == TO_CYC - 16'd1) begin
                    err_set   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tx_data     <= 8'h00;
            grant_id    <= 1'b0;
            last_grant  <= 1'b1;
            counter     <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_en) begin
                tx_data    <= pick_ram ? ram_data : cmd_data;
                grant_id   <= pick_ram;
                last_grant <= pick_ram;
            end
            if (state == LOAD) begin
                counter <= 16'd0;
            end else if (state == WAIT) begin
                counter <= counter + 16'd1;
            end
            // A new timeout outranks a clear arriving in the same cycle.
            if (err_set) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

    assign trmt    = (state == LOAD);
    assign busy    = (state != IDLE);
    assign cmd_ack = (state == ACK) && !grant_id;
    assign ram_ack = (state == ACK) && grant_id;

endmodule
